// File: rtl/apb4_bridge_pkg.sv
// Shared types and helpers for the APB4 to register-map bridge.
package apb4_bridge_pkg;

    // Low PADDR bits that must be zero for a word-aligned access.
    localparam int APB_ALIGN_BITS = 2;

    // Transfer sequencing states of the bridge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bridge_state_t;

    // Expand up to eight byte strobes into a 64-bit bit-enable mask.
    function automatic logic [63:0] strb2biten(input logic [7:0] strb);
        logic [63:0] biten;
        biten = '0;
        for (int i = 0; i < 8; i++) begin
            biten[i*8 +: 8] = {8{strb[i]}};
        end
        return biten;
    endfunction

endpackage

// File: rtl/apb4_slave_bridge.sv
// APB4 completer that turns each APB transfer into a single register-map
// request, screening misaligned and unprivileged accesses and bounding the
// register-map response time with a timeout.
module apb4_slave_bridge
    import apb4_bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int PRIV_ONLY      = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [31:0]             PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    bus_req,
    output logic                    bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wr_data,
    output logic [DATA_WIDTH-1:0]   bus_wr_biten,
    output logic                    bus_req_stall_wr,
    output logic                    bus_req_stall_rd,
    input  logic                    bus_ready,
    input  logic                    bus_err,
    input  logic [DATA_WIDTH-1:0]   bus_rd_data
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    bridge_state_t           state;
    bridge_state_t           state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   strb_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    err_next;
    logic [DATA_WIDTH-1:0]   rdata_next;
    logic                    pready_q;
    logic                    pslverr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    setup;
    logic                    reject;
    logic                    issue_wr;
    logic [63:0]             biten_full;
    logic                    unused_bits;

    assign setup  = PSEL && !PENABLE;
    assign reject = (PADDR[APB_ALIGN_BITS-1:0] != '0) || ((PRIV_ONLY == 1) && !PPROT[0]);

    // Register-map request is decoded straight from the registered request.
    assign bus_req          = (state == ISSUE);
    assign issue_wr         = bus_req && wr_q;
    assign bus_req_is_wr    = issue_wr;
    assign bus_addr         = addr_q;
    assign biten_full       = strb2biten(8'(strb_q));
    assign bus_wr_data      = issue_wr ? wdata_q : '0;
    assign bus_wr_biten     = issue_wr ? biten_full[DATA_WIDTH-1:0] : '0;
    assign bus_req_stall_wr = 1'b0;
    assign bus_req_stall_rd = 1'b0;

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

    assign unused_bits = ^{PADDR, PPROT, biten_full};

    // State register; a reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the completion status captured on the way into RESP.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        rdata_next = '0;
        case (state)
            IDLE: begin
                if (setup) begin
                    if (reject) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (bus_ready) begin
                    state_next = RESP;
                    err_next   = bus_err;
                    rdata_next = wr_q ? '0 : bus_rd_data;
                end else if (state == ISSUE) begin
                    state_next = WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the setup-phase request and run the WAIT timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (state == IDLE && setup) begin
                addr_q  <= PADDR[ADDR_WIDTH-1:0];
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
            if (state_next == ISSUE) begin
                cnt_q <= '0;
            end else if (state == WAIT) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // APB completion outputs, high for the single RESP cycle and zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= (state_next == RESP);
            pslverr_q <= err_next;
            prdata_q  <= rdata_next;
        end
    end

endmodule

// File: tb/tb_apb4_slave_bridge.sv
// Self-checking bench for apb4_slave_bridge: directed APB transfers feed a
// scoreboard, and independent monitors compare every bus_req and PREADY.
module tb_apb4_slave_bridge;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          PSEL, PENABLE, PWRITE;
    logic [31:0]   PADDR;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic          PREADY, PSLVERR;
    logic [DW-1:0] PRDATA;
    logic          bus_req, bus_req_is_wr;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data, bus_wr_biten;
    logic          bus_req_stall_wr, bus_req_stall_rd;
    logic          bus_ready, bus_err;
    logic [DW-1:0] bus_rd_data;

    always #5 clk = ~clk;

    apb4_slave_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .PRIV_ONLY(1)
    ) dut (
        .clk(clk), .rst(rst),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
        .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd),
        .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data)
    );

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] biten;
    } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    int          rsp_lat  = 0;
    logic        rsp_err  = 1'b0;
    logic [31:0] rsp_data = 32'h0;

    // Directed back-to-back table: wr, addr, wdata, strb, ack latency, bus_err, rd_data.
    logic        tab_wr   [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic [31:0] tab_addr [10] = '{32'h100, 32'h104, 32'h7FC, 32'h108, 32'h10C,
                                   32'h110, 32'h114, 32'h118, 32'h11C, 32'h120};
    logic [31:0] tab_data [10] = '{32'hA5A5A5A5, 32'h0, 32'h01234567, 32'h0, 32'hFFFF0000,
                                   32'h0, 32'h0F0F0F0F, 32'h0, 32'h87654321, 32'h0};
    logic [3:0]  tab_strb [10] = '{4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b1100,
                                   4'b0000, 4'b0110, 4'b0000, 4'b1111, 4'b0000};
    int          tab_lat  [10] = '{0, 5, 2, 4, 1, 0, 3, 2, 5, 1};
    logic        tab_err  [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    logic [31:0] tab_rd   [10] = '{32'h11112222, 32'h33334444, 32'h0, 32'h55667788, 32'h0,
                                   32'h99AABBCC, 32'h0, 32'hDEADC0DE, 32'h0, 32'h13579BDF};

    // Cycle index used to time-stamp expected events.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] expandStrb(input logic [3:0] s);
        logic [31:0] b;
        for (int i = 0; i < 4; i++) b[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
        return b;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pready"},  PREADY,        0);
        checkOutput({tag, "_pslverr"}, PSLVERR,       0);
        checkOutput({tag, "_prdata"},  PRDATA,        0);
        checkOutput({tag, "_bus_req"}, bus_req,       0);
        checkOutput({tag, "_is_wr"},   bus_req_is_wr, 0);
        checkOutput({tag, "_addr"},    bus_addr,      0);
        checkOutput({tag, "_wdata"},   bus_wr_data,   0);
        checkOutput({tag, "_biten"},   bus_wr_biten,  0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full APB transfer; expectations are queued before the setup phase.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic [2:0] prot, input int lat,
                                 input logic r_err, input logic [31:0] r_data);
        rsp_t e;
        req_t r;
        bit   done;
        rsp_lat  = lat;
        rsp_err  = r_err;
        rsp_data = r_data;
        if (addr[1:0] != 2'b00 || !prot[0]) begin
            e.cyc   = cyc + 1;
            e.err   = 1'b1;
            e.rdata = 32'h0;
        end else begin
            r.cyc   = cyc + 1;
            r.wr    = wr;
            r.addr  = addr[10:0];
            r.wdata = wr ? data : 32'h0;
            r.biten = wr ? expandStrb(strb) : 32'h0;
            req_q.push_back(r);
            if (lat <= TO) begin
                e.cyc   = cyc + 2 + lat;
                e.err   = r_err;
                e.rdata = wr ? 32'h0 : r_data;
            end else begin
                e.cyc   = cyc + 2 + TO;
                e.err   = 1'b1;
                e.rdata = 32'h0;
            end
        end
        rsp_q.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = data; PSTRB = strb; PPROT = prot;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (PREADY) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL pready_wait: got no PREADY, expected one within 20 cycles");
        end
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // RegMap model: acknowledges each request after the programmed latency.
    initial begin
        bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = 32'hBAD0BAD0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                repeat (rsp_lat) @(negedge clk);
                bus_ready = 1'b1; bus_err = rsp_err; bus_rd_data = rsp_data;
                @(negedge clk);
                bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = 32'hBAD0BAD0;
            end
        end
    end

    // Monitor: compares every completion and every register-map request.
    always @(negedge clk) begin
        rsp_t e;
        req_t r;
        if (rst) begin
            if (PREADY) begin
                if (rsp_q.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpected_pready: got PREADY=1, expected 0");
                end else begin
                    e = rsp_q.pop_front();
                    checkOutput("pready_cycle", cyc, e.cyc);
                    checkOutput("pslverr", PSLVERR, e.err);
                    checkOutput("prdata", PRDATA, e.rdata);
                end
            end else begin
                checkOutput("pslverr_idle", PSLVERR, 0);
                checkOutput("prdata_idle", PRDATA, 0);
            end
            if (bus_req) begin
                if (req_q.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpected_bus_req: got bus_req=1, expected 0");
                end else begin
                    r = req_q.pop_front();
                    checkOutput("bus_req_cycle", cyc, r.cyc);
                    checkOutput("bus_req_is_wr", bus_req_is_wr, r.wr);
                    checkOutput("bus_addr", bus_addr, r.addr);
                    checkOutput("bus_wr_data", bus_wr_data, r.wdata);
                    checkOutput("bus_wr_biten", bus_wr_biten, r.biten);
                end
            end
        end
    end

    // Directed test sequence.
    initial begin
        req_t r;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0;
        PWDATA = 32'h0; PSTRB = 4'h0; PPROT = 3'b001;
        idleCycles(3);
        checkAllZero("reset");
        checkOutput("stall_wr", bus_req_stall_wr, 0);
        checkOutput("stall_rd", bus_req_stall_rd, 0);
        rst = 1'b1;
        idleCycles(1);

        $display("[TB] write with ack in ISSUE");
        applyStimulus(1, 32'h010, 32'hDEADBEEF, 4'b0101, 3'b001, 0, 0, 32'h5555AAAA);
        $display("[TB] read with ack after 3 WAIT cycles");
        applyStimulus(0, 32'h020, 32'h0, 4'b1111, 3'b001, 3, 0, 32'h12345678);
        $display("[TB] read with timeout and late ack");
        applyStimulus(0, 32'h024, 32'h0, 4'b0000, 3'b001, 7, 0, 32'hCAFEF00D);
        idleCycles(4);
        applyStimulus(0, 32'h028, 32'h0, 4'b0000, 3'b001, 1, 0, 32'h0BADCAFE);
        $display("[TB] screened transfers");
        applyStimulus(1, 32'h013, 32'h11111111, 4'b1111, 3'b001, 0, 0, 32'h0);
        applyStimulus(0, 32'h030, 32'h0, 4'b0000, 3'b000, 0, 0, 32'h0);
        applyStimulus(1, 32'h034, 32'h22222222, 4'b0011, 3'b001, 2, 1, 32'h0);

        $display("[TB] reset during WAIT");
        rsp_lat = 2; rsp_err = 1'b0; rsp_data = 32'h77777777;
        r.cyc = cyc + 1; r.wr = 1'b1; r.addr = 11'h044;
        r.wdata = 32'hA1B2C3D4; r.biten = expandStrb(4'b1111);
        req_q.push_back(r);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h044;
        PWDATA = 32'hA1B2C3D4; PSTRB = 4'b1111; PPROT = 3'b001;
        idleCycles(1);
        PENABLE = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        #1;
        checkAllZero("wait_reset");
        PSEL = 1'b0; PENABLE = 1'b0;
        idleCycles(3);
        checkAllZero("held_reset");
        rst = 1'b1;
        idleCycles(1);
        applyStimulus(1, 32'h048, 32'hFACEB00C, 4'b1001, 3'b001, 1, 0, 32'h0);

        $display("[TB] back-to-back table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tab_wr[i], tab_addr[i], tab_data[i], tab_strb[i], 3'b001,
                          tab_lat[i], tab_err[i], tab_rd[i]);
        end
        idleCycles(8);
        checkOutput("rsp_queue_drained", rsp_q.size(), 0);
        checkOutput("req_queue_drained", req_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
